chiplet_link_arbiter: RTL

- Shares one outbound die-to-die link among NUM_SRC local requesters.
- Round-robin arbitration at packet granularity; a grant holds until the requester's last beat.
- Credit-based flow control mirrors the free slots of the remote chiplet's ingress FIFO; a beat is sent only when a credit is held.
- Sits on the transmit side, upstream of the die-to-die PHY; the remote endpoint returns one credit per FIFO entry it frees.

---
 rtl/chiplet_link_pkg.sv | 41 ++++
 rtl/chiplet_link_arbiter_if.sv | 44 ++++
 rtl/chiplet_rr_picker.sv | 30 +++
 rtl/chiplet_link_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/chiplet_link_pkg.sv
// ----------------------------------------------------------------------------
// Module  : chiplet_link_pkg
// Brief   : Shared types, link defaults and round-robin helper for the link.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package chiplet_link_pkg;

  localparam int c_def_width   = 64;
  localparam int c_def_credits = 16;
  localparam int c_max_src     = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // First requester after 'last', wrapping modulo 'num'; returns 'last' if none.
  function automatic int unsigned rr_next_idx(
    input logic [c_max_src-1:0] req,
    input logic [3:0]           last,
    input logic [4:0]           num
  );
    logic [3:0] cand;
    logic       found;
    rr_next_idx = 32'(last);
    cand        = last;
    found       = 1'b0;
    for (int k = 0; k < c_max_src; k++) begin
      cand = ({1'b0, cand} == (num - 5'd1)) ? 4'd0 : (cand + 4'd1);
      if (!found && (5'(k) < num) && req[cand]) begin
        rr_next_idx = 32'(cand);
        found       = 1'b1;
      end
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/chiplet_link_arbiter_if.sv
// ----------------------------------------------------------------------------
// Module  : chiplet_link_arbiter_if
// Brief   : Requester, link and credit signals of the die-to-die link arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface chiplet_link_arbiter_if
  import chiplet_link_pkg::*;
#(
  parameter int WIDTH   = c_def_width,
  parameter int NUM_SRC = 4,
  parameter int CREDITS = c_def_credits,
  parameter int SRC_W   = $clog2(NUM_SRC),
  parameter int CRD_W   = $clog2(CREDITS + 1)
);

  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_last;
  logic [NUM_SRC-1:0]       src_ready;
  logic [WIDTH-1:0]         link_data;
  logic                     link_valid;
  logic [SRC_W-1:0]         link_src;
  logic                     link_last;
  logic                     credit_ret;
  logic [CRD_W-1:0]         credits;
  logic                     err_credit_ovf;

  modport slave (
    input  src_data, src_valid, src_last, credit_ret,
    output src_ready, link_data, link_valid, link_src, link_last,
           credits, err_credit_ovf
  );

  modport master (
    output src_data, src_valid, src_last, credit_ret,
    input  src_ready, link_data, link_valid, link_src, link_last,
           credits, err_credit_ovf
  );

endinterface

`default_nettype wire

// File: rtl/chiplet_rr_picker.sv
// ----------------------------------------------------------------------------
// Module  : chiplet_rr_picker
// Brief   : Combinational rotate-priority encoder starting after last grant.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module chiplet_rr_picker
  import chiplet_link_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [SRC_W-1:0]   i_last_grant,
  output logic [NUM_SRC-1:0] o_grant_oh,
  output logic [SRC_W-1:0]   o_grant_idx,
  output logic               o_any
);

  logic [c_max_src-1:0] w_req_ext;

  assign w_req_ext   = c_max_src'(i_req);
  assign o_any       = |i_req;
  assign o_grant_idx = SRC_W'(rr_next_idx(w_req_ext, 4'(i_last_grant), 5'(NUM_SRC)));
  assign o_grant_oh  = o_any ? (NUM_SRC'(1) << o_grant_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/chiplet_link_arbiter.sv
// ----------------------------------------------------------------------------
// Module  : chiplet_link_arbiter
// Brief   : Packet round-robin arbiter with credit flow control onto one link.
//           Optional statistics counters under CHIPLET_ARB_STATS_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module chiplet_link_arbiter
  import chiplet_link_pkg::*;
#(
  parameter int WIDTH   = c_def_width,
  parameter int NUM_SRC = 4,
  parameter int CREDITS = c_def_credits,
  parameter int SRC_W   = $clog2(NUM_SRC),
  parameter int CRD_W   = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef CHIPLET_ARB_STATS_EN
  output logic [NUM_SRC*32-1:0] stat_pkts,
  output logic [31:0]           stat_stall_cyc,
`endif
  chiplet_link_arbiter_if.slave bus
);

  localparam logic [CRD_W-1:0] c_credits_max = CRD_W'(CREDITS);
  localparam logic [SRC_W-1:0] c_last_init   = SRC_W'(NUM_SRC - 1);

  arb_state_t         r_state;
  logic [SRC_W-1:0]   r_grant;
  logic [NUM_SRC-1:0] r_grant_oh;
  logic [SRC_W-1:0]   r_last_grant;
  logic [CRD_W-1:0]   r_credits;
  logic               r_err_ovf;
  logic [WIDTH-1:0]   r_link_data;
  logic               r_link_valid;
  logic [SRC_W-1:0]   r_link_src;
  logic               r_link_last;

  logic [NUM_SRC-1:0] w_pick_oh;
  logic [SRC_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [NUM_SRC-1:0] w_src_ready;
  logic               w_credit_ok;
  logic               w_accept;
  logic               w_last_beat;
  logic [WIDTH-1:0]   w_src_beat [NUM_SRC];

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign w_src_beat[i] = bus.src_data[i*WIDTH +: WIDTH];
    end
  endgenerate

  chiplet_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_picker (
    .i_req        (bus.src_valid),
    .i_last_grant (r_last_grant),
    .o_grant_oh   (w_pick_oh),
    .o_grant_idx  (w_pick_idx),
    .o_any        (w_pick_any)
  );

  // Only the granted source may move a beat, and only while a credit is held.
  assign w_credit_ok = (r_credits != '0);
  assign w_src_ready = ((r_state == BURST) && w_credit_ok) ? (r_grant_oh & bus.src_valid) : '0;
  assign w_accept    = |w_src_ready;
  assign w_last_beat = bus.src_last[r_grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_grant_oh   <= '0;
      r_last_grant <= c_last_init;
      r_link_data  <= '0;
      r_link_valid <= 1'b0;
      r_link_src   <= '0;
      r_link_last  <= 1'b0;
    end else begin
      r_link_valid <= w_accept;
      if (w_accept) begin
        r_link_data <= w_src_beat[r_grant];
        r_link_src  <= r_grant;
        r_link_last <= w_last_beat;
      end
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant      <= w_pick_idx;
            r_grant_oh   <= w_pick_oh;
            r_last_grant <= w_pick_idx;
            r_state      <= BURST;
          end
        end
        BURST: begin
          if (w_accept && w_last_beat) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A simultaneous accept and return cancel; a return at full count is an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= c_credits_max;
      r_err_ovf <= 1'b0;
    end else begin
      case ({w_accept, bus.credit_ret})
        2'b10: r_credits <= r_credits - CRD_W'(1);
        2'b01: begin
          if (r_credits == c_credits_max) begin
            r_err_ovf <= 1'b1;
          end else begin
            r_credits <= r_credits + CRD_W'(1);
          end
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign bus.src_ready      = w_src_ready;
  assign bus.link_data      = r_link_data;
  assign bus.link_valid     = r_link_valid;
  assign bus.link_src       = r_link_src;
  assign bus.link_last      = r_link_last;
  assign bus.credits        = r_credits;
  assign bus.err_credit_ovf = r_err_ovf;

`ifdef CHIPLET_ARB_STATS_EN
  logic [31:0] r_stat_pkts [NUM_SRC];
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_stat_pkts[i] <= '0;
      end
      r_stat_stall <= '0;
    end else begin
      if (w_accept && w_last_beat) begin
        r_stat_pkts[r_grant] <= r_stat_pkts[r_grant] + 32'd1;
      end
      if ((r_state == BURST) && bus.src_valid[r_grant] && !w_credit_ok &&
          (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_stat_out
      assign stat_pkts[i*32 +: 32] = r_stat_pkts[i];
    end
  endgenerate

  assign stat_stall_cyc = r_stat_stall;
`endif

endmodule

`default_nettype wire
